// File: rtl/mem_store_buffer.sv
// mem_store_buffer: circular store FIFO in front of a single-port memory; loads wait for the buffer to drain.
// Define MEM_STORE_BUFFER_FORWARD_EN to forward buffered store data to matching loads.
module mem_store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite_M,
    input  logic             MemRead_M,
    input  logic [WIDTH-1:0] ALUOut_M,
    input  logic [WIDTH-1:0] WriteData_M,
    output logic [WIDTH-1:0] ReadData_M,
    output logic             Stall_M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] ent_addr_q [DEPTH];
    logic [WIDTH-1:0] ent_data_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d, maddr_q, maddr_d, wdata_q, wdata_d, fwd_data;
    logic             req_q, req_d, we_q, we_d;
    logic             full, enq, deq, fwd_hit, load_ok;

    // Full is judged on the current count, so a drain this cycle admits the store only next cycle.
    assign full    = count_q == (PW+1)'(DEPTH);
    assign enq     = MemWrite_M && !full;
    assign deq     = (state_q == WRITE) && mem_ack;
    assign Stall_M = (MemWrite_M && full) || (MemRead_M && state_q != DONE && !fwd_hit);

    assign ReadData_M = rdata_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;

`ifdef MEM_STORE_BUFFER_FORWARD_EN
    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count_q && ent_addr_q[head_q + PW'(i)] == ALUOut_M) begin
                fwd_hit  = MemRead_M;
                fwd_data = ent_data_q[head_q + PW'(i)];
            end
        end
    end
    assign load_ok = !fwd_hit;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign load_ok  = count_q == '0;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        rdata_d = (state_q == READ && mem_ack) ? mem_rdata : fwd_hit ? fwd_data : rdata_q;
        case (state_q)
            IDLE: begin
                if (MemRead_M && load_ok) begin
                    state_d = READ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    maddr_d = ALUOut_M;
                end else if (count_q != '0) begin
                    state_d = WRITE;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    maddr_d = ent_addr_q[head_q];
                    wdata_d = ent_data_q[head_q];
                end
            end
            WRITE, READ: begin
                if (mem_ack) begin
                    state_d = (state_q == READ) ? DONE : IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[tail_q] <= ALUOut_M;
            ent_data_q[tail_q] <= WriteData_M;
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: scoreboard bench; memory writes and load results are checked against a
// program-order memory model ("a load returns the last value stored to that address").
module tb_mem_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite_M = 1'b0, MemRead_M = 1'b0;
    logic [31:0] ALUOut_M = '0, WriteData_M = '0;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_store_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M),
        .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M),
        .ReadData_M(ReadData_M), .Stall_M(Stall_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_rd_cyc = -100;
    int wait_cnt = 0, fix_dly = 2, cur_rand = 0;
    bit resp_on = 1'b0, rand_dly = 1'b0, force_ack = 1'b0, ld_retire = 1'b0;
    logic [63:0] exp_wr [$];
    logic [31:0] exp_ld [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] tb_mem  [logic [31:0]];
`ifdef MEM_STORE_BUFFER_FORWARD_EN
    int rd_seen = 0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as required", nm);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder and write scoreboard.
    always @(negedge clk) begin
`ifdef MEM_STORE_BUFFER_FORWARD_EN
        if (reset && mem_req && !mem_we) rd_seen++;
`endif
        if (!reset) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (!resp_on) begin
            mem_ack = force_ack;
            wait_cnt = 0;
        end else if (!mem_req || mem_ack) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= (rand_dly ? cur_rand : fix_dly)) begin
            mem_ack = 1'b1;
            wait_cnt = 0;
            cur_rand = $urandom_range(0, 3);
            if (mem_we) begin
                if (exp_wr.size() == 0) fail("write_unexpected");
                else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    check("write_addr", mem_addr, e[63:32]);
                    check("write_data", mem_wdata, e[31:0]);
                end
                tb_mem[mem_addr] = mem_wdata;
            end else begin
                mem_rdata = mem_rd(mem_addr);
                last_rd_cyc = cyc;
            end
        end else wait_cnt++;
    end

    // Load monitor: a load retires when MemRead_M is high with Stall_M low; result visible after that edge.
    always @(negedge clk) begin
        #2;
        ld_retire = reset && MemRead_M && !Stall_M;
    end

    always @(posedge clk) begin
        if (ld_retire) begin
            #1;
            if (exp_ld.size() == 0) fail("load_unexpected");
            else check("load_data", ReadData_M, exp_ld.pop_front());
        end
    end

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        MemWrite_M = wr;
        MemRead_M = rd;
        ALUOut_M = a;
        WriteData_M = d;
        #1;
        while (Stall_M && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail("stall_timeout");
        else if (wr) begin
            exp_wr.push_back({a, d});
            ref_mem[a] = d;
        end else if (rd) begin
`ifndef MEM_STORE_BUFFER_FORWARD_EN
            check("drain_before_load", 32'(exp_wr.size()), 0);
            check("load_after_read_ack", 32'(cyc - last_rd_cyc), 1);
`endif
            exp_ld.push_back(ref_rd(a));
        end
        @(posedge clk);
        #1;
        MemWrite_M = 1'b0;
        MemRead_M = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || mem_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic any_req;
        repeat (2) @(negedge clk);
        #1;
        check("reset_readdata", ReadData_M, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_stall", Stall_M, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill the buffer with memory stalled, then a fifth store must wait for the first ack.
        resp_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            MemWrite_M = 1'b1;
            ALUOut_M = 32'h10 + 32'(4 * i);
            WriteData_M = $urandom;
            #1;
            check("store_no_stall", Stall_M, 0);
            exp_wr.push_back({ALUOut_M, WriteData_M});
            ref_mem[ALUOut_M] = WriteData_M;
        end
        @(negedge clk);
        ALUOut_M = 32'h20;
        WriteData_M = $urandom;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("full_stall", Stall_M, 1);
            @(negedge clk);
            #1;
        end
        fix_dly = 2;
        resp_on = 1'b1;
        n = 0;
        while (!mem_ack && n < 20) begin
            check("full_stall_wait", Stall_M, 1);
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_in_ack_cycle", Stall_M, 1);
        @(negedge clk);
        #1;
        check("admit_after_drain", Stall_M, 0);
        exp_wr.push_back({ALUOut_M, WriteData_M});
        ref_mem[ALUOut_M] = WriteData_M;
        @(posedge clk);
        #1;
        MemWrite_M = 1'b0;

        // Second batch exercises pointer wrap.
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 32'h10 + 32'(4 * i), $urandom);
        wait_drain();

        // Empty-buffer load, ack on the first READ cycle.
        fix_dly = 0;
        tb_mem[32'h50] = 32'h1234_5678;
        ref_mem[32'h50] = 32'h1234_5678;
        @(negedge clk);
        MemRead_M = 1'b1;
        ALUOut_M = 32'h50;
        #1;
        check("lat_idle_stall", Stall_M, 1);
        @(negedge clk);
        #1;
        check("lat_read_stall", Stall_M, 1);
        check("lat_read_req", {30'b0, mem_req, mem_we}, 32'b10);
        check("lat_read_addr", mem_addr, 32'h50);
        @(negedge clk);
        #1;
        check("lat_done_nostall", Stall_M, 0);
        exp_ld.push_back(32'h1234_5678);
        @(posedge clk);
        #1;
        MemRead_M = 1'b0;
        repeat (2) @(negedge clk);

`ifndef MEM_STORE_BUFFER_FORWARD_EN
        fix_dly = 1;
        do_op(1'b1, 1'b0, 32'h30, $urandom);
        do_op(1'b1, 1'b0, 32'h34, $urandom);
        do_op(1'b0, 1'b1, 32'h40, '0);
        wait_drain();
`else
        resp_on = 1'b0;
        do_op(1'b1, 1'b0, 32'h20, 32'hAAAA);
        do_op(1'b1, 1'b0, 32'h20, 32'hBBBB);
        n = rd_seen;
        @(negedge clk);
        MemRead_M = 1'b1;
        ALUOut_M = 32'h20;
        #1;
        check("fwd_no_stall", Stall_M, 0);
        exp_ld.push_back(32'hBBBB);
        @(posedge clk);
        #1;
        MemRead_M = 1'b0;
        repeat (3) @(negedge clk);
        check("fwd_no_read", 32'(rd_seen), 32'(n));
        resp_on = 1'b1;
        wait_drain();
`endif

        // Randomized traffic over a small address pool to create reuse.
        rand_dly = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            if (r < 5) do_op(1'b1, 1'b0, a, $urandom);
            else if (r < 9) do_op(1'b0, 1'b1, a, '0);
            else @(negedge clk);
        end
        wait_drain();

        // Reset in the middle of a write discards the buffer.
        resp_on = 1'b0;
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 32'h60 + 32'(4 * i), $urandom);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("in_write_before_reset", {30'b0, mem_req, mem_we}, 32'b11);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_req", mem_req, 0);
        check("async_reset_addr", mem_addr, 0);
        exp_wr.delete();
        ref_mem = tb_mem;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        #1;
        force_ack = 1'b0;
        any_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            any_req |= mem_req;
        end
        check("no_write_after_reset", any_req, 0);
        resp_on = 1'b1;
        do_op(1'b0, 1'b1, 32'h60, '0);
        repeat (3) @(negedge clk);
        check("loads_all_retired", 32'(exp_ld.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
